// File: rtl/core_fetch_bus.sv
// Instruction-fetch bus master: one aligned 32-bit read per prefetch request, flush-aware.
// Optional FETCH_STATS_EN adds fetch_count / discard_count statistics ports.
module core_fetch_bus #(
    parameter int unsigned      PTR_W    = 30,
    parameter logic [PTR_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [PTR_W-1:0] target,
    input  logic             fetch,
    output logic             fetched,
    output logic [31:0]      fetch_data,
    output logic [PTR_W-1:0] insn_addr,
    output logic             insn_start,
    input  logic             insn_ready,
    input  logic [31:0]      insn_data
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]      fetch_count,
    output logic [31:0]      discard_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PTR_W-1:0] stale_addr_reg, stale_addr_next;
    logic             fetched_reg, fetched_next;
    logic [31:0]      fetch_data_reg, fetch_data_next;
    logic             discard_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            fetch_pc_reg   <= RESET_PC;
            stale_addr_reg <= RESET_PC;
            fetched_reg    <= 1'b0;
            fetch_data_reg <= '0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            stale_addr_reg <= stale_addr_next;
            fetched_reg    <= fetched_next;
            fetch_data_reg <= fetch_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        stale_addr_next = stale_addr_reg;
        fetched_next    = 1'b0;
        fetch_data_next = fetch_data_reg;
        discard_event   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fetch && !flush)
                    state_next = BUSY;
            end
            BUSY: begin
                if (flush) begin
                    // The outstanding read must still complete on the bus, so keep its address.
                    stale_addr_next = fetch_pc_reg;
                    state_next      = insn_ready ? IDLE : DISCARD;
                    discard_event   = insn_ready;
                end else if (insn_ready) begin
                    fetched_next    = 1'b1;
                    fetch_data_next = insn_data;
                    fetch_pc_next   = fetch_pc_reg + PTR_W'(1);
                    state_next      = fetch ? BUSY : IDLE;
                end
            end
            DISCARD: begin
                if (insn_ready) begin
                    state_next    = IDLE;
                    discard_event = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush)
            fetch_pc_next = target;
    end

    assign insn_start = (state_reg != IDLE);
    assign insn_addr  = (state_reg == DISCARD) ? stale_addr_reg : fetch_pc_reg;
    assign fetched    = fetched_reg;
    assign fetch_data = fetch_data_reg;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_reg, discard_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_reg   <= '0;
            discard_count_reg <= '0;
        end else begin
            // Counting on fetched_next keeps the count in step with the visible pulse.
            if (fetched_next)
                fetch_count_reg <= fetch_count_reg + 32'd1;
            if (discard_event)
                discard_count_reg <= discard_count_reg + 32'd1;
        end
    end

    assign fetch_count   = fetch_count_reg;
    assign discard_count = discard_count_reg;
`else
    logic unused_discard;
    assign unused_discard = discard_event;
`endif

endmodule
